// File: rtl/condicionador_entradas_if.sv
// Raw sensor inputs and conditioned outputs of the input conditioner.
// The master drives the raw levels; the slave (the conditioner) returns the debounced signals.
interface condicionador_entradas_if;
   logic btn_raw;
   logic ir_raw;
   logic btn_level;
   logic btn_press;
   logic btn_long;
   logic ir_level;
   logic ir_rise;
   logic ir_fall;

   modport master (
      output btn_raw, ir_raw,
      input  btn_level, btn_press, btn_long, ir_level, ir_rise, ir_fall
   );

   modport slave (
      input  btn_raw, ir_raw,
      output btn_level, btn_press, btn_long, ir_level, ir_rise, ir_fall
   );
endinterface

// File: rtl/condicionador_entradas.sv
// Input conditioner: synchronizes, debounces and edge-detects the push button and
// the infrared presence sensor, and flags a long button hold.
module condicionador_entradas #(
   parameter int unsigned DEBOUNCE_CYC = 20,
   parameter int unsigned LONG_CYC     = 1000
) (
   input logic                   clk,
   input logic                   rst,
   condicionador_entradas_if.slave bus
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } state_t;

   // Channel 0 is the button, channel 1 the presence sensor.
   logic [1:0] raw;
   logic [1:0] level;
   logic [1:0] level_nxt;

   assign raw = {bus.ir_raw, bus.btn_raw};

   for (genvar i = 0; i < 2; i++) begin : g_ch
      logic             sync1;
      logic             sync2;
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             lvl;
      logic             lvl_nxt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            lvl   <= 1'b0;
         end else begin
            sync1 <= raw[i];
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lvl   <= lvl_nxt;
         end
      end

      // Level flips on the edge the bounce count would reach DEBOUNCE_CYC.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         lvl_nxt   = lvl;
         unique case (state)
            STABLE_LO: begin
               if (sync2) begin
                  if (DEBOUNCE_CYC == 1) begin
                     state_nxt = STABLE_HI;
                     cnt_nxt   = '0;
                     lvl_nxt   = 1'b1;
                  end else begin
                     state_nxt = CHK_HI;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            CHK_HI: begin
               if (!sync2) begin
                  state_nxt = STABLE_LO;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                  state_nxt = STABLE_HI;
                  cnt_nxt   = '0;
                  lvl_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            STABLE_HI: begin
               if (!sync2) begin
                  if (DEBOUNCE_CYC == 1) begin
                     state_nxt = STABLE_LO;
                     cnt_nxt   = '0;
                     lvl_nxt   = 1'b0;
                  end else begin
                     state_nxt = CHK_LO;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            CHK_LO: begin
               if (sync2) begin
                  state_nxt = STABLE_HI;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                  state_nxt = STABLE_LO;
                  cnt_nxt   = '0;
                  lvl_nxt   = 1'b0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
               lvl_nxt   = 1'b0;
            end
         endcase
      end

      assign level[i]     = lvl;
      assign level_nxt[i] = lvl_nxt;
   end

   logic [HOLD_W-1:0] hold;
   logic              btn_press_q;
   logic              btn_long_q;
   logic              ir_rise_q;
   logic              ir_fall_q;

   // Edge pulses share the edge on which the level toggles; hold saturates so long fires once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold        <= '0;
         btn_press_q <= 1'b0;
         btn_long_q  <= 1'b0;
         ir_rise_q   <= 1'b0;
         ir_fall_q   <= 1'b0;
      end else begin
         btn_press_q <= level_nxt[0] & ~level[0];
         ir_rise_q   <= level_nxt[1] & ~level[1];
         ir_fall_q   <= ~level_nxt[1] & level[1];
         btn_long_q  <= level[0] && (hold == HOLD_W'(LONG_CYC - 1));
         if (!level[0]) begin
            hold <= '0;
         end else if (hold != HOLD_W'(LONG_CYC)) begin
            hold <= hold + HOLD_W'(1);
         end
      end
   end

   assign bus.btn_level = level[0];
   assign bus.ir_level  = level[1];
   assign bus.btn_press = btn_press_q;
   assign bus.btn_long  = btn_long_q;
   assign bus.ir_rise   = ir_rise_q;
   assign bus.ir_fall   = ir_fall_q;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE_CYC=4, LONG_CYC=10.
module tb_condicionador_entradas;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n_press, n_long, n_rise, n_fall;

   condicionador_entradas_if bus ();

   condicionador_entradas #(.DEBOUNCE_CYC(4), .LONG_CYC(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.btn_press) n_press++;
      if (bus.btn_long)  n_long++;
      if (bus.ir_rise)   n_rise++;
      if (bus.ir_fall)   n_fall++;
   endtask

   task automatic clr_counts();
      n_press = 0;
      n_long  = 0;
      n_rise  = 0;
      n_fall  = 0;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      clr_counts();
      bus.btn_raw = 1'b1;
      bus.ir_raw  = 1'b1;

      // Reset held with both raw inputs high
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_btn_level", bus.btn_level, 0);
      chk("rst_btn_press", bus.btn_press, 0);
      chk("rst_btn_long",  bus.btn_long,  0);
      chk("rst_ir_level",  bus.ir_level,  0);
      chk("rst_ir_rise",   bus.ir_rise,   0);
      chk("rst_ir_fall",   bus.ir_fall,   0);

      // Release with inputs already high: new rise on edge 6
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6) begin
            chk("rel_btn_level_lo", bus.btn_level, 0);
            chk("rel_ir_level_lo",  bus.ir_level,  0);
         end else if (e == 6) begin
            chk("rel_btn_level_hi", bus.btn_level, 1);
            chk("rel_ir_level_hi",  bus.ir_level,  1);
            chk("rel_btn_press",    bus.btn_press, 1);
            chk("rel_ir_rise",      bus.ir_rise,   1);
         end else begin
            chk("rel_btn_press_end", bus.btn_press, 0);
            chk("rel_ir_rise_end",   bus.ir_rise,   0);
         end
      end
      bus.btn_raw = 1'b0;
      bus.ir_raw  = 1'b0;
      repeat (12) tick();
      chk("rel_btn_fall_level", bus.btn_level, 0);
      chk("rel_ir_fall_level",  bus.ir_level,  0);
      chk("rel_press_count",    n_press, 1);
      chk("rel_long_count",     n_long,  0);
      chk("rel_fall_count",     n_fall,  1);

      // Glitch of 3 high cycles rejected, then 20-cycle hold with long press
      clr_counts();
      bus.btn_raw = 1'b1;
      repeat (3) tick();
      bus.btn_raw = 1'b0;
      repeat (2) tick();
      bus.btn_raw = 1'b1;
      for (int e = 6; e <= 25; e++) begin
         tick();
         if (e == 10) chk("glitch_level_lo", bus.btn_level, 0);
         if (e == 10) chk("glitch_press_cnt", n_press, 0);
         if (e == 11) chk("final_level_hi", bus.btn_level, 1);
         if (e == 11) chk("final_press", bus.btn_press, 1);
         if (e == 20) chk("long_early", bus.btn_long, 0);
         if (e == 21) chk("long_fire", bus.btn_long, 1);
         if (e == 22) chk("long_end", bus.btn_long, 0);
      end
      bus.btn_raw = 1'b0;
      repeat (20) tick();
      chk("hold1_press_count", n_press, 1);
      chk("hold1_long_count",  n_long,  1);
      chk("hold1_level_lo",    bus.btn_level, 0);

      // Second long hold re-arms the long pulse
      clr_counts();
      bus.btn_raw = 1'b1;
      repeat (20) tick();
      bus.btn_raw = 1'b0;
      repeat (15) tick();
      chk("hold2_press_count", n_press, 1);
      chk("hold2_long_count",  n_long,  1);

      // Short hold: 8 debounced cycles, no long pulse
      clr_counts();
      bus.btn_raw = 1'b1;
      for (int e = 1; e <= 8; e++) tick();
      bus.btn_raw = 1'b0;
      for (int e = 9; e <= 20; e++) begin
         tick();
         if (e == 13) chk("short_level_hi", bus.btn_level, 1);
         if (e == 14) chk("short_level_lo", bus.btn_level, 0);
      end
      chk("short_press_count", n_press, 1);
      chk("short_long_count",  n_long,  0);

      // Presence pulse with the button chattering every cycle
      clr_counts();
      bus.btn_raw = 1'b0;
      bus.ir_raw  = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (e == 5)  chk("ir_rise_early", bus.ir_rise, 0);
         if (e == 6)  chk("ir_rise",       bus.ir_rise, 1);
         if (e == 6)  chk("ir_level_hi",   bus.ir_level, 1);
         if (e == 7)  chk("ir_rise_end",   bus.ir_rise, 0);
         if (e == 15) chk("ir_fall_early", bus.ir_fall, 0);
         if (e == 15) chk("ir_level_hold", bus.ir_level, 1);
         if (e == 16) chk("ir_fall",       bus.ir_fall, 1);
         if (e == 16) chk("ir_level_lo",   bus.ir_level, 0);
         if (e == 17) chk("ir_fall_end",   bus.ir_fall, 0);
         chk("chatter_btn_level", bus.btn_level, 0);
         bus.btn_raw = ~bus.btn_raw;
         if (e == 10) bus.ir_raw = 1'b0;
      end
      bus.btn_raw = 1'b0;
      repeat (5) tick();
      chk("chatter_press_count", n_press, 0);
      chk("chatter_long_count",  n_long,  0);
      chk("ir_rise_count",       n_rise,  1);
      chk("ir_fall_count",       n_fall,  1);

      // Reset during CHK_HI at count 3, then release with presence high
      clr_counts();
      bus.ir_raw = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      repeat (2) tick();
      chk("midrst_ir_level", bus.ir_level, 0);
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6)  chk("midrst_level_lo", bus.ir_level, 0);
         if (e == 6) chk("midrst_level_hi", bus.ir_level, 1);
         if (e == 6) chk("midrst_rise",     bus.ir_rise,  1);
      end
      chk("midrst_rise_count", n_rise, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/condicionador_entradas.md
CONDICIONADOR_ENTRADAS -- requirements
Module: condicionador_entradas

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 20, consecutive clk cycles (20 ms at 1 kHz) a synchronized input must differ from its stable value before the stable value changes; legal range >= 1.
REQ-002 The block SHALL have parameter LONG_CYC, default 1000, clk cycles btn_level must stay 1 before btn_long fires; legal range >= 1.
REQ-003 clk  input  1  the single clock, the 1 kHz divided clock that also drives the lighting controller.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_raw  input  1  raw push-button level, 1 = pressed, asynchronous to clk.
REQ-006 ir_raw  input  1  raw infrared presence sensor level, 1 = presence, asynchronous to clk.
REQ-007 btn_level  output  1  debounced button level.
REQ-008 btn_press  output  1  one-cycle pulse on the debounced button 0->1.
REQ-009 btn_long  output  1  one-cycle pulse when the button has been held LONG_CYC cycles.
REQ-010 ir_level  output  1  debounced presence level.
REQ-011 ir_rise  output  1  one-cycle pulse on the debounced presence 0->1.
REQ-012 ir_fall  output  1  one-cycle pulse on the debounced presence 1->0.

Function
REQ-013 Each raw input SHALL pass through its own two-flop synchronizer before any other logic; the synchronized value lags raw by 2 clk edges.
REQ-014 Each channel SHALL run an identical four-state FSM: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-015 STABLE_LO -> CHK_HI when the synchronized value is 1; STABLE_HI -> CHK_LO when it is 0; the bounce counter loads 1 on entry.
REQ-016 In CHK_HI / CHK_LO, the counter increments while the synchronized value still differs from the stable value; any cycle where they match SHALL return to the previous STABLE state with the counter cleared and no output change.
REQ-017 On the edge where the counter would reach DEBOUNCE_CYC, the FSM SHALL enter the opposite STABLE state and the level output SHALL toggle on that same edge.
REQ-018 Latency: a clean raw transition SHALL reach the level output exactly DEBOUNCE_CYC+2 clk edges after the first edge that samples it; glitches shorter than DEBOUNCE_CYC cycles SHALL never reach the level output.
REQ-019 btn_press, ir_rise and ir_fall SHALL be registered and asserted high for exactly the one cycle in which the corresponding level output has just changed.
REQ-020 A hold counter SHALL clear while btn_level = 0 and increment while btn_level = 1, saturating at LONG_CYC.
REQ-021 btn_long SHALL pulse for one cycle on the edge the hold counter reaches LONG_CYC, SHALL fire at most once per press, and SHALL re-arm only after btn_level returns to 0.
REQ-022 A release before LONG_CYC cycles SHALL produce no btn_long pulse.
REQ-023 Bounce counters SHALL be $clog2(DEBOUNCE_CYC+1) bits wide and the hold counter $clog2(LONG_CYC+1) bits wide; no counter may wrap.
REQ-024 The two channels SHALL be fully independent; simultaneous transitions on both SHALL each produce their own pulses in the same cycle.

Reset
REQ-025 While rst = 1, all synchronizer flops, counters and outputs SHALL be 0 and both FSMs SHALL be in STABLE_LO, regardless of clk.
REQ-026 rst asserted mid-check SHALL discard the partial count; a raw input already 1 at rst release SHALL be debounced as a new 0->1 transition and SHALL produce its rise/press pulse.

Verification (DEBOUNCE_CYC=4, LONG_CYC=10)
REQ-027 Drive rst=1 with btn_raw=ir_raw=1 and toggle clk -> all outputs 0; release rst -> btn_level and ir_level rise on edge 6, with btn_press and ir_rise high for exactly that cycle.
REQ-028 Drive btn_raw high for 3 cycles, low for 2, then high steadily -> no output during the glitch; btn_level rises 6 edges after the final rise.
REQ-029 Hold btn_raw high for 20 cycles -> btn_press once; btn_long once, 10 cycles after btn_level rises; no repeat; after release and a new 20-cycle hold, btn_long fires again.
REQ-030 Hold btn_raw high for 8 debounced cycles, then release -> btn_press once, btn_long never, btn_level falls 6 edges after the release.
REQ-031 Drive ir_raw 0->1, hold 10 cycles, then 1->0, with btn_raw toggling concurrently -> ir_rise and ir_fall one cycle each at edge 6 after each change; button outputs unaffected.
REQ-032 Assert rst in CHK_HI at count 3, release with ir_raw=1 -> ir_level rises exactly 6 edges after release, not earlier.
